// File: rtl/can_acc_filter.sv
// Bit-serial CAN acceptance filter: assembles the arbitration field and compares ID bits on the fly.
// Optional RTR filtering is enabled by defining ACCFILT_RTR_EN (uses code_hi[13]/mask_hi[13]).
module can_acc_filter #(
  parameter bit MASK_CARE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sof,
  input  logic        rxstrobe,
  input  logic        rxbit,
  input  logic        abort,
  input  logic [15:0] code_hi,
  input  logic [15:0] code_lo,
  input  logic [15:0] mask_hi,
  input  logic [15:0] mask_lo,
  output logic        busy,
  output logic        done,
  output logic        accept,
  output logic [28:0] id,
  output logic        ide,
  output logic        rtr
);

  typedef enum logic [2:0] {IDLE, BASE, R1, IDEB, EXT, RTRB} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  bitcnt_reg, bitcnt_next;
  logic [28:0] shift_reg, shift_next;
  logic        r1_reg, r1_next;
  logic        r1_mis_reg, r1_mis_next;
  logic        mismatch_reg, mismatch_next;
  logic        done_reg, done_next;
  logic        accept_reg, accept_next;
  logic [28:0] id_reg, id_next;
  logic        ide_reg, ide_next;
  logic        rtr_reg, rtr_next;

  logic [28:0] cmp_code;
  logic [28:0] cmp_mask;
  logic        id_mis;
  logic        rtr_mis;
  logic        unused_bits;

  assign cmp_code = {code_hi[12:0], code_lo};
  assign cmp_mask = {mask_hi[12:0], mask_lo};
  assign id_mis   = (cmp_mask[bitcnt_reg] == MASK_CARE) & (rxbit ^ cmp_code[bitcnt_reg]);

`ifdef ACCFILT_RTR_EN
  assign rtr_mis = (mask_hi[13] == MASK_CARE) & (rxbit ^ code_hi[13]);
`else
  assign rtr_mis = 1'b0;
`endif

  assign unused_bits = &{1'b0, code_hi[15:13], mask_hi[15:13]};

  always_comb begin
    state_next    = state_reg;
    bitcnt_next   = bitcnt_reg;
    shift_next    = shift_reg;
    r1_next       = r1_reg;
    r1_mis_next   = r1_mis_reg;
    mismatch_next = mismatch_reg;
    done_next     = 1'b0;
    accept_next   = accept_reg;
    id_next       = id_reg;
    ide_next      = ide_reg;
    rtr_next      = rtr_reg;

    if (abort) begin
      state_next = IDLE;
    end else if (sof) begin
      // sof re-arms from any state; a strobe in the same cycle is dropped
      state_next    = BASE;
      bitcnt_next   = 5'd28;
      shift_next    = '0;
      mismatch_next = 1'b0;
      r1_mis_next   = 1'b0;
    end else if (rxstrobe) begin
      case (state_reg)
        BASE: begin
          shift_next[bitcnt_reg] = rxbit;
          mismatch_next          = mismatch_reg | id_mis;
          if (bitcnt_reg == 5'd18) state_next = R1;
          else                     bitcnt_next = bitcnt_reg - 5'd1;
        end
        R1: begin
          // RTR mismatch is held aside; it only counts if IDE shows a standard frame
          r1_next     = rxbit;
          r1_mis_next = rtr_mis;
          state_next  = IDEB;
        end
        IDEB: begin
          if (!rxbit) begin
            mismatch_next = mismatch_reg | r1_mis_reg;
            accept_next   = ~(mismatch_reg | r1_mis_reg);
            done_next     = 1'b1;
            id_next       = shift_reg;
            ide_next      = 1'b0;
            rtr_next      = r1_reg;
            state_next    = IDLE;
          end else begin
            bitcnt_next = 5'd17;
            state_next  = EXT;
          end
        end
        EXT: begin
          shift_next[bitcnt_reg] = rxbit;
          mismatch_next          = mismatch_reg | id_mis;
          if (bitcnt_reg == 5'd0) state_next = RTRB;
          else                    bitcnt_next = bitcnt_reg - 5'd1;
        end
        RTRB: begin
          mismatch_next = mismatch_reg | rtr_mis;
          accept_next   = ~(mismatch_reg | rtr_mis);
          done_next     = 1'b1;
          id_next       = shift_reg;
          ide_next      = 1'b1;
          rtr_next      = rxbit;
          state_next    = IDLE;
        end
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      bitcnt_reg   <= '0;
      shift_reg    <= '0;
      r1_reg       <= 1'b0;
      r1_mis_reg   <= 1'b0;
      mismatch_reg <= 1'b0;
      done_reg     <= 1'b0;
      accept_reg   <= 1'b0;
      id_reg       <= '0;
      ide_reg      <= 1'b0;
      rtr_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bitcnt_reg   <= bitcnt_next;
      shift_reg    <= shift_next;
      r1_reg       <= r1_next;
      r1_mis_reg   <= r1_mis_next;
      mismatch_reg <= mismatch_next;
      done_reg     <= done_next;
      accept_reg   <= accept_next;
      id_reg       <= id_next;
      ide_reg      <= ide_next;
      rtr_reg      <= rtr_next;
    end
  end

  assign busy   = (state_reg != IDLE);
  assign done   = done_reg;
  assign accept = accept_reg;
  assign id     = id_reg;
  assign ide    = ide_reg;
  assign rtr    = rtr_reg;

endmodule

// File: tb/tb_can_acc_filter.sv
// Directed bench for can_acc_filter: frames are scored against a reference model via a queue.
module tb_can_acc_filter;

  typedef struct packed {
    logic        accept;
    logic        ide;
    logic        rtr;
    logic [28:0] id;
  } result_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sof = 1'b0;
  logic        rxstrobe = 1'b0;
  logic        rxbit = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] code_hi = '0;
  logic [15:0] code_lo = '0;
  logic [15:0] mask_hi = '0;
  logic [15:0] mask_lo = '0;
  logic        busy;
  logic        done;
  logic        accept;
  logic [28:0] id;
  logic        ide;
  logic        rtr;

  int      tests = 0;
  int      fails = 0;
  int      done_count = 0;
  int      frames_expected = 0;
  result_t sb_q[$];

  always #5 clk = ~clk;

  can_acc_filter dut (
    .clk(clk), .rst(rst), .sof(sof), .rxstrobe(rxstrobe), .rxbit(rxbit), .abort(abort),
    .code_hi(code_hi), .code_lo(code_lo), .mask_hi(mask_hi), .mask_lo(mask_lo),
    .busy(busy), .done(done), .accept(accept), .id(id), .ide(ide), .rtr(rtr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference acceptance decision, derived independently of the DUT structure
  function automatic logic model_accept(input logic [28:0] idv, input logic ext, input logic rtrv);
    logic [28:0] code, mask, sel;
    logic        mis;
    code = {code_hi[12:0], code_lo};
    mask = {mask_hi[12:0], mask_lo};
    sel  = ext ? 29'h1FFF_FFFF : 29'h1FFC_0000;
    mis  = |((idv ^ code) & mask & sel);
`ifdef ACCFILT_RTR_EN
    mis = mis | (mask_hi[13] & (rtrv ^ code_hi[13]));
`else
    mis = mis | (rtrv & 1'b0);
`endif
    return ~mis;
  endfunction

  always @(negedge clk) begin
    if (rst && done) begin
      result_t e;
      done_count++;
      $display("[TB] frame done: id=0x%08h ide=%b rtr=%b accept=%b", id, ide, rtr, accept);
      check("done_busy", {31'd0, busy}, 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("accept", {31'd0, accept}, {31'd0, e.accept});
        check("id", {3'd0, id}, {3'd0, e.id});
        check("ide", {31'd0, ide}, {31'd0, e.ide});
        check("rtr", {31'd0, rtr}, {31'd0, e.rtr});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b);
    rxstrobe = 1'b1;
    rxbit    = b;
    tick();
    rxstrobe = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    strobe(b);
    tick();
  endtask

  task automatic pulse_sof();
    sof = 1'b1;
    tick();
    sof = 1'b0;
  endtask

  task automatic frame_body(input logic [28:0] idv, input logic ext, input logic srr, input logic rtrv);
    result_t e;
    for (int i = 28; i >= 18; i--) send_bit(idv[i]);
    if (ext) begin
      send_bit(srr);
      send_bit(1'b1);
      for (int i = 17; i >= 0; i--) send_bit(idv[i]);
    end else begin
      send_bit(rtrv);
    end
    e.accept = model_accept(idv, ext, rtrv);
    e.ide    = ext;
    e.rtr    = rtrv;
    e.id     = ext ? idv : {idv[28:18], 18'd0};
    sb_q.push_back(e);
    frames_expected++;
    strobe(ext ? rtrv : 1'b0);
    check("done_latency", {31'd0, done}, 32'd1);
    tick();
  endtask

  task automatic send_frame(input logic [28:0] idv, input logic ext, input logic srr, input logic rtrv);
    pulse_sof();
    frame_body(idv, ext, srr, rtrv);
  endtask

  initial begin
    logic [28:0] prev_id;
    logic        prev_acc;
    int          dc;

    repeat (3) tick();
    check("rst_outputs", {busy, done, accept, ide, rtr, id}, 34'd0);
    rst = 1'b1;
    send_bit(1'b1);
    send_bit(1'b0);
    check("idle_strobe_ignored", {31'd0, busy}, 32'd0);

    // Standard accept / reject
    code_hi = 16'h048C; code_lo = 16'h0000; mask_hi = 16'h1FFC; mask_lo = 16'h0000;
    send_frame(29'h123 << 18, 1'b0, 1'b0, 1'b0);
    check("std_accept", {31'd0, accept}, 32'd1);
    check("std_id", {3'd0, id}, 32'h048C_0000);
    send_frame(29'h122 << 18, 1'b0, 1'b0, 1'b0);
    check("std_reject", {31'd0, accept}, 32'd0);
    check("std_rej_id", {3'd0, id}, 32'h0488_0000);

    // Extended with low-byte don't-care
    code_hi = 16'h0ABC; code_lo = 16'hDEF0; mask_hi = 16'h1FFF; mask_lo = 16'hFF00;
    send_frame(29'h0ABC_DE55, 1'b1, 1'b1, 1'b0);
    check("ext_accept", {31'd0, accept}, 32'd1);
    check("ext_id", {3'd0, id}, 32'h0ABC_DE55);
    send_frame(29'h0ABC_DF55, 1'b1, 1'b1, 1'b0);
    check("ext_reject", {31'd0, accept}, 32'd0);

    // Abort after 9 extension bits
    prev_id = 29'h0ABC_DF55; prev_acc = 1'b0;
    dc = done_count;
    pulse_sof();
    for (int i = 28; i >= 18; i--) send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    for (int i = 0; i < 9; i++) send_bit(1'b1);
    check("busy_before_abort", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (4) tick();
    check("abort_no_done", dc, done_count);
    check("abort_hold_id", {3'd0, id}, {3'd0, prev_id});
    check("abort_hold_acc", {31'd0, accept}, {31'd0, prev_acc});
    // abort beats sof in the same cycle
    sof = 1'b1; abort = 1'b1;
    tick();
    sof = 1'b0; abort = 1'b0;
    check("abort_over_sof", {31'd0, busy}, 32'd0);
    send_frame(29'h0ABC_DE55 & 29'h1FFC_0000, 1'b0, 1'b0, 1'b1);

    // sof restart mid-BASE; the restarting sof carries a strobe that must be dropped
    code_hi = 16'h0000; code_lo = 16'h0000; mask_hi = 16'h0000; mask_lo = 16'h0000;
    dc = done_count;
    pulse_sof();
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    sof = 1'b1; rxstrobe = 1'b1; rxbit = 1'b0;
    tick();
    sof = 1'b0; rxstrobe = 1'b0;
    frame_body(29'h1FFC_0000, 1'b0, 1'b0, 1'b0);
    check("restart_one_done", done_count, dc + 1);
    check("restart_id", {3'd0, id}, 32'h1FFC_0000);
    check("restart_accept", {31'd0, accept}, 32'd1);

    // Reset mid-frame
    dc = done_count;
    pulse_sof();
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst_outputs", {busy, done, accept, ide, rtr, id}, 34'd0);
    repeat (3) tick();
    check("midrst_no_done", done_count, dc);

    // RTR filtering (model covers both builds)
    code_hi = 16'h0000; mask_hi = 16'h2000; mask_lo = 16'h0000;
    send_frame(29'h155 << 18, 1'b0, 1'b0, 1'b1);
`ifdef ACCFILT_RTR_EN
    check("rtr1_std", {31'd0, accept}, 32'd0);
`else
    check("rtr1_std", {31'd0, accept}, 32'd1);
`endif
    send_frame(29'h155 << 18, 1'b0, 1'b0, 1'b0);
    check("rtr0_std", {31'd0, accept}, 32'd1);
    send_frame(29'h0123_4567, 1'b1, 1'b1, 1'b1);
    send_frame(29'h0123_4567, 1'b1, 1'b1, 1'b0);
    check("rtr0_ext_srr1", {31'd0, accept}, 32'd1);

    repeat (3) tick();
    check("sb_empty", sb_q.size(), 0);
    check("done_total", done_count, frames_expected);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/can_acc_filter.md
Name: can_acc_filter

Overview:
- Bit-serial CAN acceptance filter. Sits directly downstream of the acceptance code and acceptance mask registers, and beside the receive bit-destuffer.
- Assembles the arbitration field of each received frame: 11-bit base ID, SRR/RTR, IDE, 18-bit extension ID, RTR.
- Compares each identifier bit as it arrives against the code/mask register contents.
- Emits a one-cycle completion pulse with the accept decision, consumed by the receive-buffer write control.

Parameters:
- MASK_CARE, 1, polarity of a mask bit meaning "bit must match code". With 0, a mask bit of 0 means compare.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active low
- sof  in  1  one-cycle pulse: start-of-frame detected; arms the filter
- rxstrobe  in  1  one-cycle strobe: rxbit holds a valid destuffed bit
- rxbit  in  1  destuffed received bit; dominant = 0
- abort  in  1  error/bus-off detected; abandon current frame
- code_hi  in  16  acceptance code register, high word (address 01110)
- code_lo  in  16  acceptance code register, low word (address 01111)
- mask_hi  in  16  acceptance mask register, high word (address 10000)
- mask_lo  in  16  acceptance mask register, low word (address 10001)
- busy  out  1  filter is collecting arbitration bits
- done  out  1  one-cycle pulse: arbitration field complete
- accept  out  1  frame passes filter; valid while done=1, held afterwards
- id  out  29  received identifier; standard frames use id[28:18], id[17:0]=0
- ide  out  1  received IDE bit
- rtr  out  1  received RTR bit

Behaviour:
- Bit mapping: cmp_code[28:0] = {code_hi[12:0], code_lo[15:0]}; cmp_mask[28:0] likewise from mask_hi/mask_lo.
- code_hi[15:13] and mask_hi[15:13] are unused, except under the optional feature.
- Identifier is received MSB first: the first ID bit is id[28].
- FSM states: IDLE, BASE, R1, IDEB, EXT, RTRB. All transitions happen on rising clk edges.
- Bits are consumed only on edges where rxstrobe=1.
- IDLE: waits for sof, then enters BASE. At that edge: bitcnt=28, shift register cleared, mismatch=0, busy=1.
- BASE: shifts 11 bits into id positions 28..18; after bit 18 goes to R1.
- R1: captures the bit into r1 (RTR for standard frames, SRR for extended); goes to IDEB.
- IDEB, captured bit 0: frame is standard, rtr=r1, completion at this edge.
- IDEB, captured bit 1: goes to EXT with bitcnt=17.
- EXT: shifts 18 bits into positions 17..0, then goes to RTRB.
- RTRB: captures rtr; completion at this edge.
- Per ID bit i: mismatch_next = mismatch | (care(cmp_mask[i]) & (rxbit ^ cmp_code[i])).
- Mask/code values are used as they are at the bit's strobe edge. Standard frames never evaluate bits 17..0.
- Completion edge:
  - FSM returns to IDLE.
  - done=1 for exactly one cycle; busy=0.
  - accept = ~mismatch_next.
  - id, ide, rtr are registered from the assembled values.
  - Latency: done is visible in the cycle after the strobe of the IDE bit (standard) or the final RTR bit (extended).
- id/ide/rtr/accept hold their values until the next completion. Output registers are not updated while a frame is in progress.
- rxstrobe in IDLE: ignored.
- sof while busy: restart. Current frame is discarded, no done pulse, counters re-armed as from IDLE.
- abort: takes priority over sof and rxstrobe in the same cycle. Goes to IDLE, busy=0, no done, outputs hold.
- sof and rxstrobe in the same cycle: sof wins; that bit is not consumed.
- Reset (rst=0 at an edge), including mid-frame: state=IDLE, busy=0, done=0, accept=0, id=0, ide=0, rtr=0, mismatch=0, bitcnt=0.
- All-don't-care mask: every complete frame is accepted.

Optional Feature:
- Macro ACCFILT_RTR_EN.
- Defined: the RTR bit is filtered. mask_hi[13] acts as its care bit and code_hi[13] as the expected value. The RTR mismatch term is applied at the R1 edge (standard frames) or the RTRB edge (extended frames). The SRR bit is never compared.
- Undefined: RTR is never compared, and bit 13 of both high words is ignored.

Test Plan:
- Standard accept: code_hi=0x048C, mask_hi=0x1FFC, mask_lo=0; send ID 0x123, RTR=0, IDE=0 -> done one cycle after IDE strobe, accept=1, id=0x048C0000, ide=0, rtr=0.
- Standard reject: same setup, send ID 0x122 -> done=1, accept=0, id=0x04880000.
- Extended with don't-care: code={0x0ABC,0xDEF0}, mask_hi=0x1FFF, mask_lo=0xFF00; send ID 0x0ABCDE55, SRR=1, IDE=1, RTR=0 -> accept=1, ide=1, id=0x0ABCDE55. Repeat with ID 0x0ABCDF55 -> accept=0.
- Abort mid-EXT after 9 extension bits -> busy=0, no done, outputs keep the previous frame's values. The next standard frame completes normally.
- sof re-issued mid-BASE, then a full standard frame ID 0x7FF with mask=0 -> exactly one done, accept=1, id[28:18]=0x7FF. Reset asserted mid-frame -> all outputs 0, no done.
- ACCFILT_RTR_EN defined: mask_hi=0x2000, code_hi=0x0000; RTR=1 frame -> accept=0; RTR=0 frame -> accept=1. With the macro undefined, both frames -> accept=1.
